// File: rtl/alu_pkg.sv
// Shared op-code constants and sequencer state encoding for the multi-word ALU.
// Code 0111 is unassigned and behaves as an undefined op (result 0, carry 0).
package alu_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] OP_PASS = 4'b0000;
  localparam logic [OP_W-1:0] OP_ADD  = 4'b0001;
  localparam logic [OP_W-1:0] OP_ADC  = 4'b0010;
  localparam logic [OP_W-1:0] OP_SUB  = 4'b0011;
  localparam logic [OP_W-1:0] OP_SBB  = 4'b0100;
  localparam logic [OP_W-1:0] OP_INC  = 4'b0101;
  localparam logic [OP_W-1:0] OP_DEC  = 4'b0110;
  localparam logic [OP_W-1:0] OP_AND  = 4'b1000;
  localparam logic [OP_W-1:0] OP_XOR  = 4'b1001;
  localparam logic [OP_W-1:0] OP_OR   = 4'b1010;
  localparam logic [OP_W-1:0] OP_NOT  = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_core.sv
// Single-word combinational ALU; carry/borrow is bit DATA_SIZE of the widened
// sum or difference, and is zero for pass, logic and undefined codes.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned DATA_SIZE    = 8,
  parameter int unsigned OP_CODE_SIZE = 4
) (
  input  logic [OP_CODE_SIZE-1:0] op_in,
  input  logic                    cin_in,
  input  logic [DATA_SIZE-1:0]    a_in,
  input  logic [DATA_SIZE-1:0]    b_in,
  output logic [DATA_SIZE-1:0]    y_c,
  output logic                    co_c
);

  localparam int unsigned EXT_W = DATA_SIZE + 1;

  logic [EXT_W-1:0] a_ext;
  logic [EXT_W-1:0] b_ext;
  logic [EXT_W-1:0] cin_ext;
  logic [EXT_W-1:0] sum;
  logic             arith;

  always_comb begin
    a_ext   = {1'b0, a_in};
    b_ext   = {1'b0, b_in};
    cin_ext = EXT_W'(cin_in);
    sum     = '0;
    arith   = 1'b0;
    y_c     = '0;
    co_c    = 1'b0;
    case (op_in)
      OP_CODE_SIZE'(OP_PASS): y_c = a_in;
      OP_CODE_SIZE'(OP_ADD):  begin sum = a_ext + b_ext;           arith = 1'b1; end
      OP_CODE_SIZE'(OP_ADC):  begin sum = a_ext + b_ext + cin_ext; arith = 1'b1; end
      OP_CODE_SIZE'(OP_SUB):  begin sum = a_ext - b_ext;           arith = 1'b1; end
      OP_CODE_SIZE'(OP_SBB):  begin sum = a_ext - b_ext - cin_ext; arith = 1'b1; end
      OP_CODE_SIZE'(OP_INC):  begin sum = a_ext + EXT_W'(1);       arith = 1'b1; end
      OP_CODE_SIZE'(OP_DEC):  begin sum = a_ext - EXT_W'(1);       arith = 1'b1; end
      OP_CODE_SIZE'(OP_AND):  y_c = a_in & b_in;
      OP_CODE_SIZE'(OP_XOR):  y_c = a_in ^ b_in;
      OP_CODE_SIZE'(OP_OR):   y_c = a_in | b_in;
      OP_CODE_SIZE'(OP_NOT):  y_c = ~a_in;
      default: ;
    endcase
    if (arith) begin
      y_c  = sum[DATA_SIZE-1:0];
      co_c = sum[DATA_SIZE];
    end
  end

endmodule

// File: rtl/alu_mp_seq.sv
// Multi-word ALU sequencer: runs alu_core over NUM_WORDS words, LSB word first.
// Define ALU_MP_SEQ_ZERO_FLAG_EN to add the registered zero_out result flag.
module alu_mp_seq
  import alu_pkg::*;
#(
  parameter int unsigned DATA_SIZE    = 8,
  parameter int unsigned OP_CODE_SIZE = 4,
  parameter int unsigned NUM_WORDS    = 4
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic                              start_in,
  input  logic [OP_CODE_SIZE-1:0]           op_code_in,
  input  logic                              cin_in,
  input  logic [NUM_WORDS*DATA_SIZE-1:0]    a_in,
  input  logic [NUM_WORDS*DATA_SIZE-1:0]    b_in,
  output logic                              busy_out,
  output logic                              done_out,
  output logic [NUM_WORDS*DATA_SIZE-1:0]    result_out,
  output logic                              co_out
`ifdef ALU_MP_SEQ_ZERO_FLAG_EN
  ,
  output logic                              zero_out
`endif
);

  localparam int unsigned W     = NUM_WORDS * DATA_SIZE;
  localparam int unsigned CNT_W = $clog2(NUM_WORDS);

  localparam logic [OP_CODE_SIZE-1:0] C_ADD = OP_CODE_SIZE'(OP_ADD);
  localparam logic [OP_CODE_SIZE-1:0] C_ADC = OP_CODE_SIZE'(OP_ADC);
  localparam logic [OP_CODE_SIZE-1:0] C_SUB = OP_CODE_SIZE'(OP_SUB);
  localparam logic [OP_CODE_SIZE-1:0] C_SBB = OP_CODE_SIZE'(OP_SBB);
  localparam logic [OP_CODE_SIZE-1:0] C_INC = OP_CODE_SIZE'(OP_INC);
  localparam logic [OP_CODE_SIZE-1:0] C_DEC = OP_CODE_SIZE'(OP_DEC);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [OP_CODE_SIZE-1:0] op_q, op_d;
  logic                    cin_q, cin_d;
  logic [W-1:0]            a_q, a_d;
  logic [W-1:0]            b_q, b_d;
  logic [W-1:0]            result_q, result_d;
  logic                    carry_q, carry_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic                    accept;
  logic                    last_word;
  logic [OP_CODE_SIZE-1:0] word_op;
  logic                    word_cin;
  logic [DATA_SIZE-1:0]    word_b;
  logic [DATA_SIZE-1:0]    word_y;
  logic                    word_co;

  assign accept    = start_in && (state_q != ST_RUN);
  assign last_word = (cnt_q == CNT_W'(NUM_WORDS - 1));

  // Upper words continue the chain: single-word ops become their carry forms.
  always_comb begin
    word_op  = op_q;
    word_cin = cin_q;
    word_b   = b_q[DATA_SIZE-1:0];
    if (cnt_q != '0) begin
      word_cin = carry_q;
      case (op_q)
        C_ADD, C_ADC: word_op = C_ADC;
        C_SUB, C_SBB: word_op = C_SBB;
        C_INC: begin word_op = C_ADC; word_b = '0; end
        C_DEC: begin word_op = C_SBB; word_b = '0; end
        default: ;
      endcase
    end
  end

  alu_core #(
    .DATA_SIZE    (DATA_SIZE),
    .OP_CODE_SIZE (OP_CODE_SIZE)
  ) u_alu_core (
    .op_in  (word_op),
    .cin_in (word_cin),
    .a_in   (a_q[DATA_SIZE-1:0]),
    .b_in   (word_b),
    .y_c    (word_y),
    .co_c   (word_co)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    cin_d    = cin_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    carry_d  = carry_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          op_d    = op_code_in;
          cin_d   = cin_in;
          a_d     = a_in;
          b_d     = b_in;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // Result fills from the top so word 0 lands at the bottom after the last shift.
        a_d      = a_q >> DATA_SIZE;
        b_d      = b_q >> DATA_SIZE;
        result_d = {word_y, result_q[W-1:DATA_SIZE]};
        carry_d  = word_co;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_word) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      cin_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      cin_q    <= cin_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy_out   = busy_q;
  assign done_out   = done_q;
  assign result_out = result_q;
  assign co_out     = carry_q;

`ifdef ALU_MP_SEQ_ZERO_FLAG_EN
  logic zero_q, zero_d;

  // Flag follows the final result and holds with it until the next start.
  always_comb begin
    zero_d = zero_q;
    if (accept) begin
      zero_d = 1'b0;
    end else if (state_q == ST_RUN && last_word) begin
      zero_d = (result_d == '0);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) zero_q <= 1'b0;
    else        zero_q <= zero_d;
  end

  assign zero_out = zero_q;
`endif

endmodule

// File: tb/tb_alu_mp_seq.sv
// Scoreboard bench for alu_mp_seq (4 x 8-bit words): driver pushes expected
// results, a negedge monitor pops and compares on every done_out pulse.
module tb_alu_mp_seq;

  localparam int unsigned DS  = 8;
  localparam int unsigned OPW = 4;
  localparam int unsigned NW  = 4;
  localparam int unsigned W   = NW * DS;

  logic         clk_in = 1'b0;
  logic         rst_in;
  logic         start_in;
  logic [3:0]   op_code_in;
  logic         cin_in;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy_out;
  logic         done_out;
  logic [W-1:0] result_out;
  logic         co_out;
`ifdef ALU_MP_SEQ_ZERO_FLAG_EN
  logic         zero_out;
`endif

  alu_mp_seq #(
    .DATA_SIZE    (DS),
    .OP_CODE_SIZE (OPW),
    .NUM_WORDS    (NW)
  ) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .start_in   (start_in),
    .op_code_in (op_code_in),
    .cin_in     (cin_in),
    .a_in       (a_in),
    .b_in       (b_in),
    .busy_out   (busy_out),
    .done_out   (done_out),
    .result_out (result_out),
    .co_out     (co_out)
`ifdef ALU_MP_SEQ_ZERO_FLAG_EN
    ,
    .zero_out   (zero_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  int unsigned cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    logic         co;
    int unsigned  cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk_in) begin
    if (done_out === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done_out=1 at cycle %0d expected no pending op", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("result", result_out, mon_e.res);
        chk("co", W'(co_out), W'(mon_e.co));
        chk("done_cycle", W'(cyc), W'(mon_e.cyc));
`ifdef ALU_MP_SEQ_ZERO_FLAG_EN
        chk("zero", W'(zero_out), W'(mon_e.res == '0));
`endif
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk_in);
    while (busy_out !== 1'b0 && n < 100) begin
      @(negedge clk_in);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout: got busy_out=%b expected 0 within 100 cycles", busy_out);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic c, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] er, input logic eco);
    wait_idle();
    op_code_in = op;
    cin_in     = c;
    a_in       = a;
    b_in       = b;
    start_in   = 1'b1;
    sb.push_back('{er, eco, cyc + NW + 1});
    @(negedge clk_in);
    start_in = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk_in);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int unsigned c0;
    int          n;
    logic        seen_done;

    rst_in     = 1'b1;
    start_in   = 1'b0;
    op_code_in = '0;
    cin_in     = 1'b0;
    a_in       = '0;
    b_in       = '0;

    // Reset overrides a pending start.
    repeat (2) @(negedge clk_in);
    start_in = 1'b1;
    op_code_in = 4'b0001;
    a_in = 32'h1234_5678;
    @(negedge clk_in);
    chk("rst_busy", W'(busy_out), '0);
    chk("rst_done", W'(done_out), '0);
    chk("rst_result", result_out, '0);
    chk("rst_co", W'(co_out), '0);
    start_in = 1'b0;
    rst_in   = 1'b0;
    @(negedge clk_in);
    chk("idle_busy", W'(busy_out), '0);

    // Directed vectors: op, cin, A, B, expected result, expected carry.
    issue(4'b0001, 1'b0, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0);
    issue(4'b0001, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1);
    issue(4'b0011, 1'b0, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1);
    issue(4'b0110, 1'b0, 32'h0001_0000, 32'hDEAD_BEEF, 32'h0000_FFFF, 1'b0);
    issue(4'b0100, 1'b1, 32'h0000_0005, 32'h0000_0002, 32'h0000_0002, 1'b0);
    issue(4'b1001, 1'b0, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0F0F_F0F0, 1'b0);
    issue(4'b0010, 1'b1, 32'h0000_00FF, 32'h0000_0000, 32'h0000_0100, 1'b0);
    issue(4'b0101, 1'b1, 32'h00FF_FFFF, 32'hFFFF_FFFF, 32'h0100_0000, 1'b0);
    issue(4'b0001, 1'b1, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0);
    issue(4'b0011, 1'b0, 32'h0000_0100, 32'h0000_0001, 32'h0000_00FF, 1'b0);
    issue(4'b1111, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
    issue(4'b0000, 1'b0, 32'hCAFE_BABE, 32'h1234_5678, 32'hCAFE_BABE, 1'b0);
    drain();

    // Start held high: second op may only be taken in the DONE cycle.
    wait_idle();
    c0         = cyc;
    op_code_in = 4'b0001;
    cin_in     = 1'b0;
    a_in       = 32'h0000_FFFF;
    b_in       = 32'h0000_0001;
    start_in   = 1'b1;
    sb.push_back('{32'h0001_0000, 1'b0, c0 + NW + 1});
    @(negedge clk_in);
    op_code_in = 4'b0011;
    a_in       = 32'h0000_0010;
    b_in       = 32'h0000_0020;
    sb.push_back('{32'hFFFF_FFF0, 1'b1, c0 + 2 * (NW + 1)});
    n = 0;
    while (done_out !== 1'b1 && n < 20) begin
      @(negedge clk_in);
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL b2b_done_timeout: got no done_out expected within 20 cycles");
    end
    @(negedge clk_in);
    start_in = 1'b0;
    drain();

    // Result and carry hold after completion.
    repeat (3) @(negedge clk_in);
    chk("hold_result", result_out, 32'hFFFF_FFF0);
    chk("hold_co", W'(co_out), W'(1'b1));

    // Reset in the second RUN cycle aborts with no done pulse.
    wait_idle();
    op_code_in = 4'b0001;
    cin_in     = 1'b0;
    a_in       = 32'h0101_0101;
    b_in       = 32'h0101_0101;
    start_in   = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    chk("abort_busy", W'(busy_out), '0);
    chk("abort_done", W'(done_out), '0);
    chk("abort_result", result_out, '0);
    chk("abort_co", W'(co_out), '0);
`ifdef ALU_MP_SEQ_ZERO_FLAG_EN
    chk("abort_zero", W'(zero_out), '0);
`endif
    seen_done = 1'b0;
    repeat (10) begin
      @(negedge clk_in);
      if (done_out !== 1'b0) seen_done = 1'b1;
    end
    chk("abort_no_done", W'(seen_done), '0);
    chk("abort_queue_empty", W'(sb.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected bench completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_mp_seq.md
ALU_MP_SEQ -- requirements
Module: alu_mp_seq

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 8, width of one ALU word.
REQ-002 SHALL have parameter OP_CODE_SIZE, default 4, op-code width.
REQ-003 SHALL have parameter NUM_WORDS, default 4, words per operand; legal range 2..8.
REQ-004 SHALL have ports:
- clk_in  input  1  clock; single clock domain.
- rst_in  input  1  reset, synchronous, active-high.
- start_in  input  1  request to begin one operation.
- op_code_in  input  OP_CODE_SIZE  operation code.
- cin_in  input  1  carry/borrow-in for ADC/SBB.
- a_in  input  NUM_WORDS*DATA_SIZE  operand A.
- b_in  input  NUM_WORDS*DATA_SIZE  operand B.
- busy_out  output  1  high while a sequence is running.
- done_out  output  1  one-cycle completion pulse.
- result_out  output  NUM_WORDS*DATA_SIZE  wide result.
- co_out  output  1  final carry/borrow.

Function
REQ-005 SHALL accept start_in only when busy_out=0; on acceptance, register op_code_in, cin_in, a_in and b_in; start_in while busy_out=1 SHALL be ignored.
REQ-006 SHALL implement FSM IDLE -> RUN (on accepted start) -> DONE (after last word) -> IDLE, or DONE -> RUN on accepted start.
REQ-007 SHALL process one word per cycle in RUN, LSB word first, word k in the k-th RUN cycle; done_out SHALL be high in cycle NUM_WORDS+1 after acceptance (5 for default).
REQ-008 SHALL use op code unmodified for word 0, with cin = captured cin_in; cin is ignored by all op codes except 010 and 100.
REQ-009 For words k>0 SHALL remap op code: 001/010 -> 010; 011/100 -> 100; 101 -> 010 with B forced 0; 110 -> 100 with B forced 0; all others unchanged; cin = carry register.
REQ-010 SHALL load the carry register with the ALU word carry-out every RUN cycle; co_out SHALL equal the word NUM_WORDS-1 carry-out, where carry = bit DATA_SIZE of the (DATA_SIZE+1)-bit sum/difference (borrow for subtraction).
REQ-011 Logic ops (1000-1011), pass (0000) and undefined codes SHALL produce co_out=0; undefined codes SHALL produce result 0.
REQ-012 result_out and co_out SHALL hold stable from done_out until the next accepted start; during RUN they SHALL update word by word.
REQ-013 busy_out SHALL be high in RUN only; done_out high in DONE only.
REQ-014 No output or internal register SHALL be inferred as a latch.

Reset
REQ-015 rst_in high at a clock edge SHALL force IDLE, busy_out=0, done_out=0, result_out=0, co_out=0, carry register=0, overriding start_in.
REQ-016 Reset during RUN SHALL abort the sequence with no done_out pulse.

Configuration
REQ-017 With ALU_MP_SEQ_ZERO_FLAG_EN defined, SHALL add output zero_out (1 bit), registered, high with done_out-stable result when result_out is all zeros, reset 0; without it, the port and logic SHALL not exist.

Structure
REQ-018 Op-code constants (0000..1011) and FSM state encoding SHALL live in shared package alu_pkg.
REQ-019 The word ALU SHALL be sub-module alu_core: combinational, DATA_SIZE-wide, default-assigned outputs, blocking assignments only.
REQ-020 Sequencer (FSM, word counter, operand shifters, carry register) SHALL reside in alu_mp_seq.

Verification (NUM_WORDS=4, DATA_SIZE=8)
REQ-021 ADD 0001, A=0x000000FF, B=0x00000001 -> result 0x00000100, co 0, done_out in cycle 5.
REQ-022 ADD 0001, A=0xFFFFFFFF, B=0x00000001 -> result 0x00000000, co 1 (zero_out=1 if enabled).
REQ-023 SUB 0011, A=0x00000000, B=0x00000001 -> result 0xFFFFFFFF, co 1; DEC 0110, A=0x00010000 -> 0x0000FFFF, co 0.
REQ-024 SBB 0100, cin=1, A=0x00000005, B=0x00000002 -> 0x00000002, co 0; XOR 1001, A=0xF0F0F0F0, B=0xFFFF0000 -> 0x0F0FF0F0, co 0.
REQ-025 start_in held high through RUN -> second op begins only from the DONE cycle; back-to-back results both correct.
REQ-026 rst_in asserted in RUN cycle 2 -> next cycle IDLE, all outputs 0, no done_out.
